// File: rtl/pi_input_sequencer_water.sv
// pi_input_sequencer_water: step sequencer feeding x = ref - meas to the water-loop PI block and collecting y.
// Optional `PI_SEQ_HOLD_EN adds a hold input that loads x with +0 to freeze the integrator.
module pi_seq_fp_sub #(
   parameter int LAT = 7
) (
   input  logic        clk,
   input  logic        aclr,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] d
);
   logic [31:0] ax, bx, big, sml, pipe_d;
   logic [LAT-1:0][31:0] pipe_q;
   logic [7:0]  eb, es, dexp;
   logic [23:0] mb, ms;
   logic [49:0] shf;
   logic [26:0] sm27, norm;
   logic [27:0] sum;
   logic [4:0]  lz, sh;
   logic [8:0]  er, ef;
   logic [31:0] ef_frac;
   logic        nan_a, nan_b, inf_a, inf_b, rnd;
   function automatic logic [4:0] lzc27(input logic [26:0] v);
      lzc27 = 5'd27;
      for (int i = 0; i < 27; i++) if (v[i]) lzc27 = 5'(26 - i);
   endfunction
   always_comb begin
      ax = a;
      bx = {~b[31], b[30:0]};
      big = (bx[30:0] > ax[30:0]) ? bx : ax;
      sml = (bx[30:0] > ax[30:0]) ? ax : bx;
      eb = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
      es = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
      mb = {big[30:23] != 8'd0, big[22:0]};
      ms = {sml[30:23] != 8'd0, sml[22:0]};
      dexp = eb - es;
      shf = (dexp > 8'd49) ? 50'd0 : ({ms, 26'd0} >> dexp);
      sm27 = {shf[49:24], |shf[23:0]};
      sum = (big[31] ^ sml[31]) ? {1'b0, mb, 3'b0} - {1'b0, sm27} : {1'b0, mb, 3'b0} + {1'b0, sm27};
      lz = lzc27(sum[26:0]);
      // subnormal results: never shift the exponent below 1
      sh = ({4'd0, lz} < {1'b0, eb} - 9'd1) ? lz : 5'(eb - 8'd1);
      norm = sum[27] ? {sum[27:2], |sum[1:0]} : sum[26:0] << sh;
      er = sum[27] ? {1'b0, eb} + 9'd1 : {1'b0, eb} - {4'd0, sh};
      ef = norm[26] ? er : 9'd0;
      rnd = norm[2] & (norm[3] | norm[1] | norm[0]);
      ef_frac = {ef, norm[25:3]} + {31'd0, rnd};
      nan_a = &ax[30:23] & |ax[22:0];
      nan_b = &bx[30:23] & |bx[22:0];
      inf_a = &ax[30:23] & ~|ax[22:0];
      inf_b = &bx[30:23] & ~|bx[22:0];
      pipe_d = (ef_frac[31:23] >= 9'd255) ? {big[31], 8'hFF, 23'd0} : {big[31], ef_frac[30:0]};
      pipe_d = (sum == 28'd0) ? {big[31] & sml[31], 31'd0} : pipe_d;
      pipe_d = (nan_a | nan_b | (inf_a & inf_b & (ax[31] ^ bx[31]))) ? 32'h7FC00000 :
               inf_a ? ax : inf_b ? bx : pipe_d;
   end
   always_ff @(posedge clk or posedge aclr)
      if (aclr) pipe_q <= '0;
      else pipe_q <= {pipe_q[LAT-2:0], pipe_d};
   assign d = pipe_q[LAT-1];
endmodule

module pi_input_sequencer_water #(
   parameter int ADD_LAT  = 7,
   parameter int LEAD_CYC = 15,
   parameter int TIMEOUT  = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step_start,
   input  logic [31:0] ref_in,
   input  logic [31:0] meas,
   input  logic        clr_int,
`ifdef PI_SEQ_HOLD_EN
   input  logic        hold,
`endif
   output logic [31:0] x,
   output logic        done_read_x,
   output logic        sta,
   output logic        rst_user,
   input  logic        done_sig,
   input  logic [31:0] y,
   output logic [31:0] u_out,
   output logic        step_done,
   output logic        busy,
   output logic        overrun_err,
   output logic        timeout_err
);
   typedef enum logic [1:0] {S_IDLE, S_SUB, S_LEAD, S_WAIT} state_t;
   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] ref_q, ref_d, meas_q, meas_d, x_q, x_d, u_out_q, u_out_d, diff, load_val;
   logic        done_read_x_q, done_read_x_d, sta_q, sta_d, step_done_q, step_done_d;
   logic        overrun_q, overrun_d, timeout_q, timeout_d, rst_user_q;
   pi_seq_fp_sub #(.LAT(ADD_LAT)) u_sub (.clk(clk), .aclr(~rst), .a(ref_q), .b(meas_q), .d(diff));
`ifdef PI_SEQ_HOLD_EN
   logic hold_q, hold_d;
   assign hold_d = (state_q == S_IDLE && step_start) ? hold : hold_q;
   assign load_val = hold_q ? 32'h00000000 : diff;
   always_ff @(posedge clk) hold_q <= !rst ? 1'b0 : hold_d;
`else
   assign load_val = diff;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q + 8'd1;
      ref_d = ref_q;
      meas_d = meas_q;
      x_d = x_q;
      u_out_d = u_out_q;
      done_read_x_d = 1'b0;
      sta_d = 1'b0;
      step_done_d = 1'b0;
      overrun_d = overrun_q | (step_start & (state_q != S_IDLE));
      timeout_d = timeout_q;
      case (state_q)
         S_IDLE: if (step_start) begin
            ref_d = ref_in;
            meas_d = meas;
            cnt_d = 8'd0;
            state_d = S_SUB;
         end
         S_SUB: if (cnt_q == 8'(ADD_LAT)) begin
            x_d = load_val;
            done_read_x_d = 1'b1;
            cnt_d = 8'd0;
            state_d = S_LEAD;
         end
         S_LEAD: if (cnt_q == 8'(LEAD_CYC - 1)) begin
            sta_d = 1'b1;
            cnt_d = 8'd0;
            state_d = S_WAIT;
         end
         // a late done_sig on the expiry cycle still wins over the timeout
         S_WAIT: if (done_sig) begin
            u_out_d = y;
            step_done_d = 1'b1;
            state_d = S_IDLE;
         end else if (cnt_q == 8'(TIMEOUT)) begin
            timeout_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         ref_q <= '0;
         meas_q <= '0;
         x_q <= '0;
         u_out_q <= '0;
         done_read_x_q <= 1'b0;
         sta_q <= 1'b0;
         step_done_q <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
         rst_user_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         ref_q <= ref_d;
         meas_q <= meas_d;
         x_q <= x_d;
         u_out_q <= u_out_d;
         done_read_x_q <= done_read_x_d;
         sta_q <= sta_d;
         step_done_q <= step_done_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
         rst_user_q <= clr_int;
      end
   end
   assign x = x_q;
   assign u_out = u_out_q;
   assign done_read_x = done_read_x_q;
   assign sta = sta_q;
   assign step_done = step_done_q;
   assign overrun_err = overrun_q;
   assign timeout_err = timeout_q;
   assign rst_user = rst_user_q;
   assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_pi_input_sequencer_water.sv
// tb_pi_input_sequencer_water: randomized steps checked against a real-arithmetic step model.
module tb_pi_input_sequencer_water;
   logic        clk = 1'b0, rst = 1'b0, step_start = 1'b0, clr_int = 1'b0, done_sig = 1'b0, hold_v = 1'b0;
   logic [31:0] ref_v = '0, meas_v = '0, y_v = '0;
   logic [31:0] x, u_out;
   logic        done_read_x, sta, rst_user, step_done, busy, overrun_err, timeout_err;
   int          n_chk = 0, n_err = 0;
   logic [31:0] m_x = '0, m_u = '0;
   logic        m_ov = 1'b0, m_to = 1'b0, last_clr = 1'b0;
   always #5 clk = ~clk;
   pi_input_sequencer_water dut (
      .clk(clk), .rst(rst), .step_start(step_start), .ref_in(ref_v), .meas(meas_v), .clr_int(clr_int),
`ifdef PI_SEQ_HOLD_EN
      .hold(hold_v),
`endif
      .x(x), .done_read_x(done_read_x), .sta(sta), .rst_user(rst_user), .done_sig(done_sig), .y(y_v),
      .u_out(u_out), .step_done(step_done), .busy(busy), .overrun_err(overrun_err), .timeout_err(timeout_err)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic real p2(input int s);
      p2 = 1.0;
      for (int i = 0; i < (s < 0 ? -s : s); i++) p2 = (s < 0) ? p2 / 2.0 : p2 * 2.0;
   endfunction
   function automatic real dec(input logic [31:0] b);
      if (b[30:0] == 31'd0) return 0.0;
      dec = (1.0 + $itor(b[22:0]) / 8388608.0) * p2(int'(b[30:23]) - 127);
      if (b[31]) dec = -dec;
   endfunction
   function automatic logic [31:0] enc(input real v);
      real a;
      int  e, f;
      if (v == 0.0) return 32'h0;
      a = (v < 0.0) ? -v : v;
      e = 127;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0) begin a = a * 2.0; e--; end
      f = $rtoi((a - 1.0) * 8388608.0);
      enc = {v < 0.0, 8'(e), 23'(f)};
   endfunction
   function automatic logic [31:0] rnd_op(input int s);
      int k;
      k = int'($urandom_range(0, 4000)) - 2000;
      rnd_op = enc($itor(k) / 16.0 * p2(s));
   endfunction
   task automatic run_step(input logic [31:0] r, input logic [31:0] m, input int lat,
                           input logic [31:0] yv, input int ov_at, input bit spur);
      logic [31:0] xe;
      bit ok;
      int fin;
      xe = hold_v ? 32'h0 : enc(dec(r) - dec(m));
      ok = lat >= 0 && lat <= 64;
      fin = ok ? 25 + lat : 89;
      for (int k = 0; k <= fin; k++) begin
         step_start = (k == 0) || (k == ov_at);
         ref_v = (k == 0) ? r : $urandom;
         meas_v = (k == 0) ? m : $urandom;
         done_sig = (lat >= 0 && k == 24 + lat) || (spur && k == 12);
         y_v = (k == 24 + lat) ? yv : $urandom;
         clr_int = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (k == 9) m_x = xe;
         if (ok && k == fin) m_u = yv;
         if (!ok && k == fin) m_to = 1'b1;
         if (ov_at > 0 && k == ov_at + 1) m_ov = 1'b1;
         chk("x", x, m_x);
         chk("u_out", u_out, m_u);
         chk("done_read_x", 32'(done_read_x), 32'(k == 9));
         chk("sta", 32'(sta), 32'(k == 24));
         chk("step_done", 32'(step_done), 32'(ok && k == fin));
         chk("busy", 32'(busy), 32'(k >= 1 && k < fin));
         chk("overrun_err", 32'(overrun_err), 32'(m_ov));
         chk("timeout_err", 32'(timeout_err), 32'(m_to));
         chk("rst_user", 32'(rst_user), 32'(last_clr));
         last_clr = clr_int;
         tick();
      end
      step_start = 1'b0;
      done_sig = 1'b0;
   endtask
   initial begin
      int s, lat;
      tick();
      tick();
      @(negedge clk);
      chk("rst x", x, 32'h0);
      chk("rst outs", {26'd0, done_read_x, sta, step_done, busy, overrun_err, timeout_err}, 32'h0);
      rst = 1'b1;
      tick();
      run_step(32'h3F800000, 32'h3E800000, 30, 32'h3FC00000, 30, 1'b0);
      chk("tp x", x, 32'h3F400000);
      chk("tp u_out", u_out, 32'h3FC00000);
      chk("tp overrun", 32'(overrun_err), 32'd1);
      run_step(rnd_op(0), rnd_op(0), -1, 32'hDEADBEEF, -1, 1'b0);
      chk("to u_out kept", u_out, 32'h3FC00000);
      run_step(rnd_op(3), rnd_op(3), 64, 32'h40490FDB, -1, 1'b1);
      run_step(rnd_op(-4), rnd_op(-4), 0, 32'hC1200000, -1, 1'b0);
      run_step(rnd_op(1), rnd_op(1), 65, 32'h12345678, -1, 1'b0);
      for (int k = 0; k <= 21; k++) begin
         step_start = (k == 0);
         ref_v = 32'h40000000;
         meas_v = 32'h3F800000;
         rst = (k != 20);
         clr_int = (k == 20);
         if (k < 21) tick();
      end
      @(negedge clk);
      chk("mid rst x", x, 32'h0);
      chk("mid rst u_out", u_out, 32'h0);
      chk("mid rst outs", {25'd0, rst_user, done_read_x, sta, step_done, busy, overrun_err, timeout_err}, 32'h0);
      clr_int = 1'b0;
      m_x = '0; m_u = '0; m_ov = 1'b0; m_to = 1'b0; last_clr = 1'b0;
      for (int k = 22; k < 80; k++) begin
         tick();
         done_sig = (k == 54);
         y_v = 32'h3F000000;
         @(negedge clk);
         chk("post rst quiet", {29'd0, sta, step_done, busy}, 32'h0);
      end
      done_sig = 1'b0;
      tick();
      chk("post rst u_out", u_out, 32'h0);
      run_step(32'h3F800000, 32'h3E800000, 30, 32'h3FC00000, -1, 1'b0);
      for (int n = 0; n < 10; n++) begin
         s = int'($urandom_range(0, 20)) - 10;
         lat = int'($urandom_range(0, 70));
         run_step(rnd_op(s), rnd_op(s), lat, $urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 24)) : -1,
                  1'($urandom_range(0, 1)));
      end
`ifdef PI_SEQ_HOLD_EN
      hold_v = 1'b1;
      run_step(32'h3F800000, 32'h3E800000, 30, 32'h3FC00000, -1, 1'b0);
      chk("hold x", x, 32'h0);
      hold_v = 1'b0;
`endif
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
